// File: rtl/vx_stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer slice.
// LOG2UP gives a select width that stays at least one bit for single-lane builds.
`ifndef VX_LOG2UP_DEFINED
`define VX_LOG2UP_DEFINED
`define LOG2UP(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package vx_stream_demux_pkg;

  // Depth of every per-lane elastic buffer.
  localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/vx_demux_skid_buf.sv
// Two-entry per-lane FIFO with the head in entry 0; outputs come straight from registers.
// Push is only issued by the parent while the buffer is not full.
module vx_demux_skid_buf
  import vx_stream_demux_pkg::*;
#(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] data_in,
  output logic             full,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  logic [1:0]       count_r;
  logic [DATAW-1:0] entry0_r;
  logic [DATAW-1:0] entry1_r;
  logic             pop_s;

  assign pop_s     = (count_r != 2'd0) & ready_out;
  assign full      = (count_r == 2'(SKID_DEPTH));
  assign valid_out = (count_r != 2'd0);
  assign data_out  = entry0_r;

  // Occupancy count: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= 2'd0;
    end else begin
      case ({push, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage is not reset; its content only matters while count is non-zero.
  always_ff @(posedge clk) begin
    case ({push, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          entry0_r <= data_in;
        end else begin
          entry1_r <= data_in;
        end
      end
      2'b01: begin
        entry0_r <= entry1_r;
      end
      2'b11: begin
        if (count_r == 2'd1) begin
          entry0_r <= data_in;
        end else begin
          entry0_r <= entry1_r;
          entry1_r <= data_in;
        end
      end
      default: begin
        entry0_r <= entry0_r;
        entry1_r <= entry1_r;
      end
    endcase
  end

endmodule

// File: rtl/vx_stream_demux.sv
// 1-to-N registered stream demultiplexer: each lane has its own skid buffer, so a
// stalled lane only blocks beats addressed to it. Out-of-range selects are consumed and dropped.
module vx_stream_demux
  import vx_stream_demux_pkg::*;
#(
  parameter int DATAW = 1,
  parameter int N     = 1,
  parameter int LN    = `LOG2UP(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [DATAW-1:0]          data_in,
  input  logic [LN-1:0]             sel_in,
  output logic                      ready_in,
  output logic [N-1:0]              valid_out,
  output logic [N-1:0][DATAW-1:0]   data_out,
  input  logic [N-1:0]              ready_out
);

  logic [N-1:0] full_s;
  logic [N-1:0] sel_hit_s;
  logic [N-1:0] push_s;
  logic         lane_full_s;
  logic         out_of_range_s;
  logic         fire_s;

  generate
    if (N == 1) begin : g_single
      logic unused_sel_s;
      assign unused_sel_s   = ^sel_in;
      assign sel_hit_s      = 1'b1;
      assign lane_full_s    = full_s[0];
      assign out_of_range_s = 1'b0;
    end else begin : g_multi
      // One-hot lane decode and the fullness of the addressed lane.
      always_comb begin
        sel_hit_s   = {N{1'b0}};
        lane_full_s = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (sel_in == LN'(i)) begin
            sel_hit_s[i] = 1'b1;
            lane_full_s  = full_s[i];
          end else begin
            sel_hit_s[i] = 1'b0;
          end
        end
      end
      assign out_of_range_s = ({1'b0, sel_in} >= (LN+1)'(N));
    end
  endgenerate

  // An out-of-range beat is always accepted; with no lane hit it simply vanishes.
  assign ready_in = reset & (out_of_range_s | ~lane_full_s);
  assign fire_s   = valid_in & ready_in;
  assign push_s   = sel_hit_s & {N{fire_s}};

  generate
    for (genvar g = 0; g < N; g++) begin : g_lane
      vx_demux_skid_buf #(.DATAW(DATAW)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s[g]),
        .data_in   (data_in),
        .full      (full_s[g]),
        .valid_out (valid_out[g]),
        .data_out  (data_out[g]),
        .ready_out (ready_out[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_vx_stream_demux.sv
// Directed bench for vx_stream_demux with N=4, N=2 and N=3 instances sharing clock and reset.
// Expected values are hand-derived; the N=2 streaming run uses per-lane queues.
module tb_vx_stream_demux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            a_valid_in, a_ready_in;
  logic [7:0]      a_data_in;
  logic [1:0]      a_sel_in;
  logic [3:0]      a_valid_out, a_ready_out;
  logic [3:0][7:0] a_data_out;

  logic            b_valid_in, b_ready_in;
  logic [7:0]      b_data_in;
  logic [0:0]      b_sel_in;
  logic [1:0]      b_valid_out, b_ready_out;
  logic [1:0][7:0] b_data_out;

  logic            c_valid_in, c_ready_in;
  logic [7:0]      c_data_in;
  logic [1:0]      c_sel_in;
  logic [2:0]      c_valid_out, c_ready_out;
  logic [2:0][7:0] c_data_out;

  vx_stream_demux #(.DATAW(8), .N(4)) u_a (
    .clk(clk), .reset(reset), .valid_in(a_valid_in), .data_in(a_data_in), .sel_in(a_sel_in),
    .ready_in(a_ready_in), .valid_out(a_valid_out), .data_out(a_data_out), .ready_out(a_ready_out));

  vx_stream_demux #(.DATAW(8), .N(2)) u_b (
    .clk(clk), .reset(reset), .valid_in(b_valid_in), .data_in(b_data_in), .sel_in(b_sel_in),
    .ready_in(b_ready_in), .valid_out(b_valid_out), .data_out(b_data_out), .ready_out(b_ready_out));

  vx_stream_demux #(.DATAW(8), .N(3)) u_c (
    .clk(clk), .reset(reset), .valid_in(c_valid_in), .data_in(c_data_in), .sel_in(c_sel_in),
    .ready_in(c_ready_in), .valid_out(c_valid_out), .data_out(c_data_out), .ready_out(c_ready_out));

  int vecs = 0;
  int fails = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [1:0] exp_b_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    reset = 1'b0;
    a_valid_in = 1'b0; a_data_in = 8'h00; a_sel_in = 2'd0; a_ready_out = 4'b1111;
    b_valid_in = 1'b0; b_data_in = 8'h00; b_sel_in = 1'b0; b_ready_out = 2'b11;
    c_valid_in = 1'b0; c_data_in = 8'h00; c_sel_in = 2'd0; c_ready_out = 3'b111;
    tick();
    tick();
    #1;
    chk("rst_valid", {28'd0, a_valid_out}, 32'h0);
    chk("rst_ready_forced0", {31'd0, a_ready_in}, 32'h0);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, a_ready_in}, 32'h1);
    chk("post_rst_valid_b", {30'd0, b_valid_out}, 32'h0);

    // Route 0xA1 to lane 2
    a_valid_in = 1'b1; a_sel_in = 2'd2; a_data_in = 8'hA1;
    #1;
    chk("route_ready", {31'd0, a_ready_in}, 32'h1);
    tick();
    a_valid_in = 1'b0;
    chk("route_valid", {28'd0, a_valid_out}, 32'h4);
    chk("route_data", {24'd0, a_data_out[2]}, 32'hA1);
    tick();
    chk("route_drained", {28'd0, a_valid_out}, 32'h0);

    // Back-pressure on lane 1
    a_ready_out = 4'b1101;
    a_valid_in = 1'b1; a_sel_in = 2'd1; a_data_in = 8'h10;
    tick();
    a_data_in = 8'h11;
    #1;
    chk("bp_second_ready", {31'd0, a_ready_in}, 32'h1);
    tick();
    a_data_in = 8'h12;
    #1;
    chk("bp_third_blocked", {31'd0, a_ready_in}, 32'h0);
    chk("bp_valid", {28'd0, a_valid_out}, 32'h2);
    chk("bp_head", {24'd0, a_data_out[1]}, 32'h10);

    // Lane independence: lane 3 beats interleaved with blocked lane-1 attempts
    for (int k = 0; k < 4; k++) begin
      a_sel_in = 2'd3; a_data_in = 8'h30 + 8'(k);
      #1;
      chk("indep_l3_ready", {31'd0, a_ready_in}, 32'h1);
      tick();
      chk("indep_l3_valid", {28'd0, a_valid_out}, 32'hA);
      chk("indep_l3_data", {24'd0, a_data_out[3]}, 32'h30 + 32'(k));
      a_sel_in = 2'd1; a_data_in = 8'h12;
      #1;
      chk("indep_l1_blocked", {31'd0, a_ready_in}, 32'h0);
      tick();
      chk("indep_l1_valid", {28'd0, a_valid_out}, 32'h2);
      chk("indep_l1_head", {24'd0, a_data_out[1]}, 32'h10);
    end

    // Release lane 1 with 0x12 still held on the input
    a_ready_out = 4'b1111;
    #1;
    chk("rel_still_full", {31'd0, a_ready_in}, 32'h0);
    tick();
    chk("rel_pop1", {24'd0, a_data_out[1]}, 32'h11);
    chk("rel_ready_back", {31'd0, a_ready_in}, 32'h1);
    tick();
    a_valid_in = 1'b0;
    chk("rel_pop2", {24'd0, a_data_out[1]}, 32'h12);
    chk("rel_valid", {28'd0, a_valid_out}, 32'h2);
    tick();
    chk("rel_empty", {28'd0, a_valid_out}, 32'h0);

    // Out-of-range drop and per-select ready on N=3
    c_ready_out = 3'b000;
    c_valid_in = 1'b1; c_sel_in = 2'd3; c_data_in = 8'hFF;
    #1;
    chk("oor_ready", {31'd0, c_ready_in}, 32'h1);
    tick();
    chk("oor_no_valid", {29'd0, c_valid_out}, 32'h0);
    c_sel_in = 2'd2; c_data_in = 8'h21;
    tick();
    c_data_in = 8'h22;
    tick();
    chk("c_l2_full", {31'd0, c_ready_in}, 32'h0);
    c_sel_in = 2'd3;
    #1;
    chk("c_oor_ready_when_l2_full", {31'd0, c_ready_in}, 32'h1);
    c_valid_in = 1'b0;
    chk("c_l2_valid", {29'd0, c_valid_out}, 32'h4);
    chk("c_l2_head", {24'd0, c_data_out[2]}, 32'h21);
    c_ready_out = 3'b111;
    tick();
    chk("c_l2_second", {24'd0, c_data_out[2]}, 32'h22);
    tick();
    chk("c_empty", {29'd0, c_valid_out}, 32'h0);

    // Full-rate streaming on N=2 with per-lane scoreboards
    exp_b_valid = 2'b00;
    for (int k = 0; k < 100; k++) begin
      chk("stream_valid", {30'd0, b_valid_out}, {30'd0, exp_b_valid});
      if (b_valid_out[0]) begin
        if (q0.size() == 0) chk("stream_l0_extra", 32'h1, 32'h0);
        else chk("stream_l0_data", {24'd0, b_data_out[0]}, {24'd0, q0.pop_front()});
      end
      if (b_valid_out[1]) begin
        if (q1.size() == 0) chk("stream_l1_extra", 32'h1, 32'h0);
        else chk("stream_l1_data", {24'd0, b_data_out[1]}, {24'd0, q1.pop_front()});
      end
      b_valid_in = 1'b1;
      b_sel_in = 1'($urandom_range(0, 1));
      b_data_in = 8'(k);
      #1;
      chk("stream_ready", {31'd0, b_ready_in}, 32'h1);
      if (b_sel_in == 1'b0) begin
        q0.push_back(8'(k));
        exp_b_valid = 2'b01;
      end else begin
        q1.push_back(8'(k));
        exp_b_valid = 2'b10;
      end
      tick();
    end
    b_valid_in = 1'b0;
    chk("stream_last_valid", {30'd0, b_valid_out}, {30'd0, exp_b_valid});
    if (b_valid_out[0] && q0.size() != 0) chk("stream_l0_last", {24'd0, b_data_out[0]}, {24'd0, q0.pop_front()});
    if (b_valid_out[1] && q1.size() != 0) chk("stream_l1_last", {24'd0, b_data_out[1]}, {24'd0, q1.pop_front()});
    tick();
    chk("stream_drained", {30'd0, b_valid_out}, 32'h0);
    chk("stream_q_left", 32'(q0.size() + q1.size()), 32'h0);

    // Mid-stream reset on N=4 with lanes 0 and 2 full
    a_ready_out = 4'b0000;
    a_valid_in = 1'b1; a_sel_in = 2'd0; a_data_in = 8'h01;
    tick();
    a_data_in = 8'h02;
    tick();
    a_sel_in = 2'd2; a_data_in = 8'h03;
    tick();
    a_data_in = 8'h04;
    tick();
    chk("mid_valid_before", {28'd0, a_valid_out}, 32'h5);
    a_ready_out = 4'b1111;
    reset = 1'b0;
    a_sel_in = 2'd1; a_data_in = 8'h77;
    #1;
    chk("mid_ready_in_reset", {31'd0, a_ready_in}, 32'h0);
    tick();
    reset = 1'b1;
    a_valid_in = 1'b0;
    chk("mid_flushed", {28'd0, a_valid_out}, 32'h0);
    a_valid_in = 1'b1; a_sel_in = 2'd0; a_data_in = 8'h55;
    #1;
    chk("mid_ready_after", {31'd0, a_ready_in}, 32'h1);
    tick();
    a_valid_in = 1'b0;
    chk("mid_new_valid", {28'd0, a_valid_out}, 32'h1);
    chk("mid_new_data", {24'd0, a_data_out[0]}, 32'h55);
    tick();
    chk("mid_no_stale", {28'd0, a_valid_out}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/vx_stream_demux.md
# vx_stream_demux

Registered 1-to-N stream demultiplexer: routes each accepted input beat to one of N output lanes chosen by a per-beat select, with an independent 2-entry elastic buffer on every lane. It is the distribution side of the N-to-1 mux used on arbitrated paths. Examples are fanning a shared response bus back to per-requester queues, or steering issued instructions to execution lanes. A stalled lane never blocks beats bound for the other lanes.

## Interface
- DATAW, 1, payload width in bits
- N, 1, number of output lanes (N ≥ 1)
- LN, `LOG2UP(N)`, select width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low: 0 = in reset, sampled on rising edge of clk
- valid_in  input  1  input beat valid
- data_in  input  DATAW  input payload
- sel_in  input  LN  destination lane; ignored when N = 1
- ready_in  output  1  input beat accepted this cycle when valid_in & ready_in
- valid_out  output  N  per-lane output valid
- data_out  output  N×DATAW  per-lane payload, packed [N-1:0][DATAW-1:0]
- ready_out  input  N  per-lane downstream ready

## Operation
- Each lane owns a 2-entry FIFO, the skid buffer, with head at entry 0 and occupancy count 0..2.
- ready_in = (sel_in ≥ N) | (count[sel_in] != 2), forced 0 while reset = 0. It depends on sel_in only, never on valid_in.
- Input fire (valid_in & ready_in) with sel_in < N writes data_in to the tail of lane sel_in.
- Input fire with sel_in ≥ N (only possible for non-power-of-2 N) consumes the beat and discards it. No lane changes.
- Lane fire (valid_out[i] & ready_out[i]) pops the head. Entry 1 shifts to entry 0.
- Same-cycle push and pop on one lane:
  - count unchanged;
  - with count 1: new data becomes head;
  - with count 2: entry 1 moves to head and the new data is written to entry 1.
- valid_out[i] = (count[i] != 0). data_out[i] = head entry. Both come straight from registers, with no combinational path from input to output.
- Per-lane beat order is preserved. There is no ordering across lanes.
- N = 1: degenerates to a single 2-entry skid buffer. sel_in is unused (UNUSED_VAR).

## Timing
- Reset (reset = 0 at an edge): all counts → 0. After the edge valid_out = 0 and ready_in = 1. Data registers are not reset; their content is don't-care.
- Reset mid-operation flushes all buffered beats. Beats presented during the reset cycle are not accepted.
- Latency: an input fire at edge k makes valid_out[sel] = 1 in the cycle after edge k, when the lane was empty.
- Throughput: 1 beat/cycle sustained into any lane whose ready_out is held 1.
- Full lane (count 2): ready_in = 0 for that sel_in. It reasserts in the cycle after that lane fires.
- Upstream may change sel_in and data_in while ready_in = 0. Once valid_in is asserted, it is held until fire.

## Structure
- Shared package holds no new typedefs. LN uses the common `LOG2UP` macro.
- One sub-module, `vx_demux_skid_buf`:
  - parameter DATAW;
  - ports clk, reset, push, data_in, full, valid_out, data_out, ready_out;
  - instantiated N times in a generate loop.
- The top level holds only ready_in decode, push one-hot decode (sel_in → push[i]) and the out-of-range drop.
- Target size ≈150–200 lines total.

## Test plan
- Reset then route: N=4, DATAW=8. Release reset, send 0xA1 to lane 2 → valid_out = 4'b0100 next cycle with data_out[2] = 0xA1; other lanes stay invalid.
- Back-pressure: N=4, ready_out[1] = 0. Send 0x10, 0x11, 0x12 to lane 1 → first two accepted, ready_in = 0 on the third. Raise ready_out[1] → lane outputs 0x10 then 0x11, and 0x12 is accepted the cycle after the first pop.
- Lane independence: lane 1 full and stalled. Alternate sel 1/3 beats → every beat to lane 3 is accepted with no bubbles; lane 1 contents remain 0x10, 0x11.
- Full-rate streaming: N=2, ready_out = 2'b11. Send 100 beats with random sel and incrementing data → ready_in held 1 throughout; per-lane output sequence matches a per-lane scoreboard; no loss or duplication.
- Out-of-range drop: N=3, send sel_in = 3 with 0xFF → ready_in = 1, beat consumed, valid_out stays 3'b000.
- Mid-stream reset: two lanes holding 2 beats each. Assert reset = 0 for one cycle → valid_out = 0 the next cycle. A new beat 0x55 to lane 0 then emerges alone, with no stale data.
